// File: rtl/dac_sample_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : dac_sample_feeder
//  Description : Paces 16-bit samples into the DAC8811 serialiser. Buffers
//                producer samples in a small FIFO and presents exactly one
//                sample per DAC frame on a registered, stable output. Also
//                reports the FIFO level and a sticky underflow flag.
//  Revision    : 1.0  initial release
// ============================================================================
module dac_sample_feeder #(
  parameter  int DEPTH        = 16,
  parameter  int FRAME_CYCLES = 41,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          enable,
  input  logic [15:0]   wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic [15:0]   dac_data,
  output logic          sample_tick,
  output logic [AW:0]   level,
  output logic          underflow,
  input  logic          underflow_clr
);

  // Frame counter width; FRAME_CYCLES is at least 2, so this is at least 1.
  localparam int            FW           = $clog2(FRAME_CYCLES);
  localparam logic [FW-1:0] C_FRAME_LAST = FW'(FRAME_CYCLES - 1);
  localparam logic [AW:0]   C_FULL_LEVEL = (AW + 1)'(DEPTH);

  // Sample storage carries no reset; only pointers and the level define
  // which entries are meaningful.
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [FW-1:0] r_fcnt;

  logic w_full;
  logic w_empty;
  logic w_wr_en;
  logic w_boundary;
  logic w_pop;

  // Full/empty are judged on the level at the start of the cycle, so a
  // same-cycle pop never opens room for a write and a same-cycle write never
  // feeds a pop.
  assign w_full     = (level == C_FULL_LEVEL);
  assign w_empty    = (level == '0);
  assign wr_ready   = nrst && !w_full;
  assign w_wr_en    = wr_valid && wr_ready;
  assign w_boundary = enable && (r_fcnt == C_FRAME_LAST);
  assign w_pop      = w_boundary && !w_empty;

  // Store accepted words; no reset so the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Write and read pointers; DEPTH is a power of two so they wrap naturally.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy: write-only raises, pop-only lowers, both or neither holds.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      level <= '0;
    end else begin
      case ({w_wr_en, w_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Frame counter runs only while enabled; dropping enable restarts the frame
  // so the first boundary after re-enable is a full frame away.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_fcnt <= '0;
    end else if (!enable) begin
      r_fcnt <= '0;
    end else if (r_fcnt == C_FRAME_LAST) begin
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + 1'b1;
    end
  end

  // Output sample register and its one-cycle "new value" marker.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      dac_data    <= 16'h0000;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= w_pop;
      if (w_pop) begin
        dac_data <= r_mem[r_rd_ptr];
      end
    end
  end

  // Sticky underflow: an empty FIFO at a frame boundary sets it, and a set
  // event beats a coincident clear.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      underflow <= 1'b0;
    end else if (w_boundary && w_empty) begin
      underflow <= 1'b1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dac_sample_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dac_sample_feeder
//  Description : Self-checking bench for dac_sample_feeder. A queue-based
//                reference model tracks the buffered samples, the frame
//                position and the expected outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dac_sample_feeder;

  localparam int DEPTH        = 16;
  localparam int FRAME_CYCLES = 41;
  localparam int AW           = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          enable = 1'b0;
  logic [15:0]   wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [15:0]   dac_data;
  logic          sample_tick;
  logic [AW:0]   level;
  logic          underflow;
  logic          underflow_clr = 1'b0;

  dac_sample_feeder #(
    .DEPTH        (DEPTH),
    .FRAME_CYCLES (FRAME_CYCLES)
  ) dut (
    .clk           (clk),
    .nrst          (nrst),
    .enable        (enable),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .dac_data      (dac_data),
    .sample_tick   (sample_tick),
    .level         (level),
    .underflow     (underflow),
    .underflow_clr (underflow_clr)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] m_q[$];
  logic [15:0] m_dac   = 16'h0000;
  logic        m_tick  = 1'b0;
  logic        m_uf    = 1'b0;
  int          m_phase = 0;     // cycles elapsed in the current frame

  int n_vec = 0;
  int n_err = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs at negedge, check wr_ready, advance the
  // model at the edge, then check the registered outputs.
  task automatic cycle(input logic rn, input logic en, input logic v,
                       input logic [15:0] d, input logic clr);
    logic acc;
    logic bnd;
    logic was_empty;
    @(negedge clk);
    nrst = rn; enable = en; wr_valid = v; wr_data = d; underflow_clr = clr;
    #1;
    check_value("wr_ready", {31'b0, wr_ready}, {31'b0, (rn && (m_q.size() < DEPTH))});
    @(posedge clk);
    if (!rn) begin
      m_q.delete();
      m_dac = 16'h0000; m_tick = 1'b0; m_uf = 1'b0; m_phase = 0;
    end else begin
      acc       = v && (m_q.size() < DEPTH);
      bnd       = en && (m_phase == FRAME_CYCLES - 1);
      was_empty = (m_q.size() == 0);
      m_tick    = 1'b0;
      if (bnd && !was_empty) begin
        m_dac  = m_q.pop_front();
        m_tick = 1'b1;
      end
      if (bnd && was_empty) m_uf = 1'b1;
      else if (clr)         m_uf = 1'b0;
      if (acc) m_q.push_back(d);
      m_phase = en ? (m_phase + 1) % FRAME_CYCLES : 0;
    end
    #1;
    check_value("dac_data",    {16'b0, dac_data},    {16'b0, m_dac});
    check_value("sample_tick", {31'b0, sample_tick}, {31'b0, m_tick});
    check_value("level",       {27'b0, level},       m_q.size());
    check_value("underflow",   {31'b0, underflow},   {31'b0, m_uf});
  endtask

  task automatic idle(input int n, input logic en);
    for (int i = 0; i < n; i++) cycle(1'b1, en, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
  endtask

  // Run enabled idle cycles until the next cycle is a frame boundary.
  task automatic to_boundary();
    while (m_phase != FRAME_CYCLES - 1) cycle(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic drain();
    while (m_q.size() > 0) cycle(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic fill_to(input int n);
    while (m_q.size() < n) cycle(1'b1, 1'b0, 1'b1, 16'($urandom), 1'b0);
  endtask

  initial begin
    logic       en_r;
    int         pct;
    logic [15:0] seq3 [3];
    seq3[0] = 16'h1234; seq3[1] = 16'hABCD; seq3[2] = 16'hFFFF;

    // Reset, then three known samples paced one per frame.
    do_reset(3);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, seq3[i], 1'b0);
    idle(4 * FRAME_CYCLES, 1'b1);

    // Fill to capacity with the frame counter held, attempt one extra write,
    // then pop across many frames while writes keep the pointers wrapping.
    do_reset(1);
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 1'b0, 1'b1, 16'(16'h0100 + i), 1'b0);
    for (int i = 0; i < 40 * FRAME_CYCLES; i++)
      cycle(1'b1, 1'b1, ($urandom_range(0, 99) < 4), 16'($urandom), 1'b0);

    // Underflow, clear coinciding with a new underflow, then a lone clear.
    drain();
    to_boundary();
    cycle(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    idle(5, 1'b1);
    to_boundary();
    cycle(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
    idle(3, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
    idle(3, 1'b1);

    // Write into an empty FIFO exactly at a boundary.
    to_boundary();
    cycle(1'b1, 1'b1, 1'b1, 16'hBEEF, 1'b0);
    idle(FRAME_CYCLES + 2, 1'b1);

    // Write and pop together at level 5, then at full.
    do_reset(1);
    fill_to(5);
    to_boundary();
    cycle(1'b1, 1'b1, 1'b1, 16'h5555, 1'b0);
    fill_to(DEPTH);
    to_boundary();
    cycle(1'b1, 1'b1, 1'b1, 16'h6666, 1'b0);
    idle(3, 1'b1);

    // One-cycle reset mid-frame with 8 buffered, then a fresh write.
    do_reset(1);
    fill_to(8);
    idle(10, 1'b1);
    do_reset(1);
    idle(FRAME_CYCLES + 3, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 16'h7777, 1'b0);
    idle(FRAME_CYCLES + 3, 1'b1);

    // Randomized traffic with varying write rates, enable toggling,
    // occasional clears and resets.
    en_r = 1'b1;
    for (int seg = 0; seg < 12; seg++) begin
      case (seg % 4)
        0:       pct = 2;
        1:       pct = 4;
        2:       pct = 30;
        default: pct = 90;
      endcase
      for (int i = 0; i < 1200; i++) begin
        if ($urandom_range(0, 299) == 0) en_r = ~en_r;
        cycle(($urandom_range(0, 2999) != 0), en_r,
              ($urandom_range(0, 99) < pct), 16'($urandom),
              ($urandom_range(0, 49) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dac_sample_feeder.md
# dac_sample_feeder

Sample pacing stage directly upstream of the DAC8811 serial driver. It accepts 16-bit unsigned samples from a producer over a valid/ready handshake and buffers them in a small FIFO. Once per DAC frame it pops one sample onto a registered, stable parallel output, which the serialiser captures at any point in its frame. It also reports buffer level and a sticky underflow flag.

## Interface
- DEPTH, 16: FIFO entries; power of two, at least 2.
- AW, log2(DEPTH): address width; derived, not overridden.
- FRAME_CYCLES, 41: clk cycles per output sample; one serialiser frame at 100 MHz; at least 2.
- clk  in  1  single clock; all logic on posedge.
- nrst  in  1  reset; synchronous, active-low.
- enable  in  1  high: frame counter runs and pops occur; low: counter held at 0, no pops.
- wr_data  in  16  unsigned sample from producer.
- wr_valid  in  1  producer has a sample on wr_data.
- wr_ready  out  1  FIFO can accept; equals !full, forced 0 while nrst is low.
- dac_data  out  16  registered sample to serialiser `data` input; changes only on a pop.
- sample_tick  out  1  one-cycle pulse, coincident with the first cycle of a new dac_data value.
- level  out  AW+1  FIFO occupancy, 0..DEPTH.
- underflow  out  1  sticky: a frame boundary found the FIFO empty.
- underflow_clr  in  1  clears underflow.

## Operation
- Write: accepted in a cycle with wr_valid && wr_ready. The word is stored at wr_ptr, and wr_ptr increments modulo DEPTH (wrap from DEPTH-1 to 0).
- Full: level == DEPTH, so wr_ready = 0. No write is accepted while full, even if a pop occurs in the same cycle. wr_ready is computed from the current level, not the post-pop level.
- Frame counter fcnt: counts 0..FRAME_CYCLES-1 while enable = 1, then wraps to 0. A frame boundary is the cycle with enable && fcnt == FRAME_CYCLES-1.
- At a frame boundary with level > 0: pop the head word into dac_data, increment rd_ptr modulo DEPTH, and assert sample_tick on the next cycle.
- At a frame boundary with level == 0: dac_data holds its last value, sample_tick stays 0, and underflow is set.
- Write and pop in the same cycle: level is unchanged. Write to an empty FIFO at a boundary: the write is accepted, the pop does not occur, and underflow is set. Empty status is judged before the write.
- enable falling: fcnt is cleared to 0 on the next cycle and dac_data holds. enable rising: the first boundary occurs FRAME_CYCLES cycles later.
- underflow_clr and an underflow event in the same cycle: set wins.
- level is updated as +1 on write only, -1 on pop only, and unchanged on both or neither. It never exceeds DEPTH and never goes below 0.
- FIFO storage is not reset. Only pointers, counters and outputs are reset.

## Timing
- Reset (nrst = 0 at a clk edge) sets: dac_data = 16'h0000, sample_tick = 0, underflow = 0, level = 0, fcnt = 0, and both pointers = 0. wr_ready = 0 while nrst is low and 1 from the first cycle after release.
- Reset asserted mid-operation discards all buffered samples; dac_data returns to 0x0000 on the next edge.
- Write latency: a word written in cycle n is counted in level in cycle n+1 and is eligible for a pop at any boundary in cycle n+1 or later.
- Pop latency: boundary in cycle b, then dac_data and sample_tick update at cycle b+1. dac_data then stays constant for at least FRAME_CYCLES cycles.
- Pop rate: at most one pop per FRAME_CYCLES cycles, in steady state exactly one every FRAME_CYCLES cycles.
- All outputs are registered except wr_ready.

## Test plan
- Reset release, then write 0x1234, 0xABCD and 0xFFFF with enable = 1: dac_data shows 0x1234, then 0xABCD, then 0xFFFF. The values are 41 cycles apart, each starting with a one-cycle sample_tick, and level steps 3, 2, 1, 0.
- Fill to capacity with enable = 0: after 16 writes, level = 16 and wr_ready = 0. A 17th wr_valid is not accepted. Entries 0..15 then pop in order, with pointer wrap verified over 40 sample cycles.
- Underflow: let the FIFO drain with enable = 1. At the next boundary, dac_data holds its last value, no tick occurs, and underflow = 1. The flag stays set until underflow_clr is pulsed, and the flag remains set if the clear coincides with a new underflow.
- Simultaneous write and pop at a boundary with level = 5: level remains 5 and the popped value is the oldest entry. With level = 16, the write is rejected and level becomes 15.
- Write into an empty FIFO at the boundary cycle: the word is stored, level = 1, underflow = 1, and the word pops at the next boundary.
- Assert nrst low for 1 cycle while level = 8, mid-frame: next cycle, level = 0, dac_data = 0x0000, underflow = 0, fcnt = 0, and the first later tick needs a new write plus a full frame.
